dmem_banked: RTL and testbench
==============================

Name: dmem_banked

Overview:
- Parametrised successor to the single-cycle byte data memory.
- Storage is organised as rows of DATA_W bits with per-byte write enables.
- Provides a valid/ready request/response interface with byte, half and word sizes, little-endian byte order, sign/zero extension on loads, and misalignment error reporting.
- Sits between the core's load/store unit and on-chip data storage; one outstanding request at a time.

Parameters:
- ADDR_W, 10: byte-address width; capacity = 2**ADDR_W bytes.
- DATA_W, 32: row and word width in bits. Must be 16, 32 or 64. NB = DATA_W/8 bytes per row.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word (DATA_W), 3 = illegal
- req_signed  in  1  sign-extend load result (byte/half only)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  load data, extended; 0 for stores and errors
- rsp_err  out  1  request rejected (illegal size or misaligned)

Behaviour:
- Reset (reset = 0, async):
  - state goes to IDLE; req_ready = 0 while asserted, then 1 in IDLE.
  - rsp_valid, rsp_err and rsp_rdata are all 0.
  - The storage array is NOT cleared. Preload image is bytes 0..19 = words 0x00000000, 0x99127254, 0x12345678, 0x89117843, 0x12418549 (little-endian at byte addresses 0, 4, 8, 12, 16); all other bytes are 0 at time zero.
- FSM states: IDLE, SPLIT, RESP.
  - IDLE: req_ready = 1. A request is accepted on an edge where req_valid & req_ready.
  - Accept of an aligned or legal in-row access: the row is read and/or byte-enabled write is performed on that edge; go to RESP. rsp_valid is high in the next cycle, giving 1-cycle latency.
  - Accept of a row-crossing access (feature enabled only): the first-row part is performed; go to SPLIT, req_ready = 0.
  - SPLIT: second row (row+1, wrapping to row 0 past the top of memory) is read/written on the next edge; go to RESP. Latency is 2 cycles.
  - RESP: rsp_valid = 1; outputs held stable until rsp_valid & rsp_ready; then go to IDLE. req_ready = 0 in RESP, so there is no back-to-back accept in the same cycle as the response handshake.
- Size bytes S = 1, 2 or NB.
  - Stores write only the S bytes starting at req_addr.
  - Loads return those bytes in the low bits; upper bits are sign bit replicated if req_signed, else 0.
  - For word loads, req_signed is ignored.
- Errors (rsp_err = 1, rsp_rdata = 0, no array write, 1-cycle latency):
  - req_size = 3.
  - req_size = 2 and NB = 2 is legal. Size encoding beyond NB is never illegal, because word always equals NB.
  - Misaligned access (addr mod S != 0) when the feature is disabled.
- Reset mid-SPLIT: the first-row write of the access persists; the second part is dropped; no response is issued.
- A store then a load to the same address returns the new data (write completes before RESP).

Optional Feature:
- Macro: DMEM_BANKED_MISALIGN_EN.
- Defined:
  - Misaligned accesses within one row complete in 1 cycle via byte lanes.
  - Accesses crossing a row boundary use SPLIT and complete in 2 cycles, with wrap-around at the top address.
  - rsp_err is raised only for req_size = 3.
- Undefined:
  - Any misaligned access returns rsp_err = 1 with no write.
  - The SPLIT state is not synthesised.

Decomposition:
- Package dmem_pkg:
  - Size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state typedef.
  - Preload word constants.
  - Function size_to_bytes.
- Sub-module dmem_lane_align: combinational byte-lane shifter producing write-enable mask and shifted write data, and extracting/extending load data from one or two rows. Instantiated once.
- The top level holds the FSM and array.

Test Plan:
- Reset, then load word at address 8 → rsp_rdata = 0x12345678, rsp_err = 0, rsp_valid one cycle after accept.
- Load byte addr 7, signed → 0xFFFFFF99. Unsigned → 0x00000099. Load half addr 4, signed → 0x00007254.
- Store byte 0xAB at addr 5, then load word addr 4 → 0x9912AB54. Bytes 4, 6 and 7 are unchanged.
- Hold rsp_ready = 0 for 3 cycles → rsp_valid/rsp_rdata stable, req_ready = 0. Release → next request accepted the following cycle.
- Word load addr 6:
  - Feature off → rsp_err = 1, rdata = 0.
  - Feature on → 0x56789912 after 2 cycles.
  - Feature on, word store at top address 1022 → bytes 1022, 1023, 0, 1 written.
- req_size = 3 → rsp_err = 1, no write. Assert reset during SPLIT → rsp_valid = 0, req_ready = 1 after release, first-row bytes updated.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants, state encoding and helpers for the banked data memory.
// Used by dmem_banked (optional misaligned support: DMEM_BANKED_MISALIGN_EN).
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SPLIT = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

    localparam logic [31:0] PRELOAD_W0 = 32'h0000_0000;
    localparam logic [31:0] PRELOAD_W1 = 32'h9912_7254;
    localparam logic [31:0] PRELOAD_W2 = 32'h1234_5678;
    localparam logic [31:0] PRELOAD_W3 = 32'h8911_7843;
    localparam logic [31:0] PRELOAD_W4 = 32'h1241_8549;

    localparam int unsigned PRELOAD_BYTES = 20;
    localparam logic [159:0] PRELOAD_IMAGE =
        {PRELOAD_W4, PRELOAD_W3, PRELOAD_W2, PRELOAD_W1, PRELOAD_W0};

    function automatic int unsigned size_to_bytes(input logic [1:0] size, input int unsigned nb);
        case (size)
            SZ_BYTE: return 1;
            SZ_HALF: return 2;
            SZ_WORD: return nb;
            default: return nb;
        endcase
    endfunction

    function automatic logic [7:0] preload_byte(input int unsigned idx);
        logic [159:0] img;
        img = PRELOAD_IMAGE >> (idx * 8);
        if (idx < PRELOAD_BYTES) begin
            return img[7:0];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane shifter: store mask/data placement for one row half,
// and load extraction with sign/zero extension from a two-row window.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NB    = DATA_W / 8,
    localparam int unsigned OW    = $clog2(NB)
) (
    input  logic [OW-1:0]     off,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic              hi,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] row0,
    input  logic [DATA_W-1:0] row1,
    output logic [NB-1:0]     wmask,
    output logic [DATA_W-1:0] wrow,
    output logic [DATA_W-1:0] rdata
);
    logic [OW+2:0]       sh;
    int unsigned         nbytes;
    logic [NB-1:0]       bmask;
    logic [2*NB-1:0]     mask2;
    logic [2*DATA_W-1:0] wshift;
    logic [DATA_W-1:0]   rlow;
    logic [7:0]          fill;

    assign sh = {off, 3'b000};

    always_comb begin
        nbytes = size_to_bytes(size, NB);
        bmask  = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (i < int'(nbytes)) bmask[i] = 1'b1;
        end
        // hi selects the part of the access that lands in the following row
        mask2  = {{NB{1'b0}}, bmask} << off;
        wshift = {{DATA_W{1'b0}}, wdata} << sh;
        wmask  = hi ? mask2[2*NB-1:NB] : mask2[NB-1:0];
        wrow   = hi ? wshift[2*DATA_W-1:DATA_W] : wshift[DATA_W-1:0];

        rlow = DATA_W'({row1, row0} >> sh);
        case (size)
            SZ_BYTE: fill = {8{sgn & rlow[7]}};
            SZ_HALF: fill = {8{sgn & rlow[15]}};
            default: fill = 8'h00;
        endcase
        rdata = '0;
        for (int i = 0; i < int'(NB); i++) begin
            rdata[i*8 +: 8] = (i < int'(nbytes)) ? rlow[i*8 +: 8] : fill;
        end
    end

endmodule

// File: rtl/dmem_banked.sv
// Row-organised data memory with valid/ready request/response interface.
// Define DMEM_BANKED_MISALIGN_EN to support misaligned and row-crossing accesses.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OW    = $clog2(NB);
    localparam int unsigned RW    = ADDR_W - OW;
    localparam int unsigned NROWS = 2 ** RW;

    // Array holds the difference from the preload image, so zero power-up contents
    // read back as the image without any initialisation sequence.
    logic [DATA_W-1:0] mem_delta [NROWS];

    state_t            state_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic [RW-1:0]     req_row;
    logic [OW-1:0]     req_off;
    int unsigned       nbytes;
    logic              size_bad;
    logic              err;
    logic              accept;

    logic              in_split;
    logic [RW-1:0]     cur_row;
    logic [OW-1:0]     cur_off;
    logic [1:0]        cur_size;
    logic              cur_sgn;
    logic              cur_we;
    logic [DATA_W-1:0] cur_wdata;

    logic [RW-1:0]     row1_a;
    logic [RW-1:0]     waddr;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] wpre;
    logic [NB-1:0]     wmask;
    logic [DATA_W-1:0] wrow;
    logic [DATA_W-1:0] rdata_al;
    logic              mem_we;

    function automatic logic [DATA_W-1:0] preload_row(input logic [RW-1:0] r);
        logic [DATA_W-1:0] v;
        for (int b = 0; b < int'(NB); b++) begin
            v[b*8 +: 8] = preload_byte(32'(r) * NB + 32'(b));
        end
        return v;
    endfunction

    assign req_row   = req_addr[ADDR_W-1:OW];
    assign req_off   = req_addr[OW-1:0];
    assign req_ready = reset & (state_q == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef DMEM_BANKED_MISALIGN_EN
    logic              cross;
    logic [RW-1:0]     row_q;
    logic [OW-1:0]     off_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    always_comb begin
        nbytes   = size_to_bytes(req_size, NB);
        size_bad = (req_size == SZ_ILLEGAL);
        cross    = (32'(req_off) + nbytes) > NB;
        err      = size_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q   <= '0;
            off_q   <= '0;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            row_q   <= req_row;
            off_q   <= req_off;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            we_q    <= req_we;
            wdata_q <= req_wdata;
        end
    end

    assign in_split  = (state_q == ST_SPLIT);
    assign cur_row   = in_split ? row_q   : req_row;
    assign cur_off   = in_split ? off_q   : req_off;
    assign cur_size  = in_split ? size_q  : req_size;
    assign cur_sgn   = in_split ? sgn_q   : req_signed;
    assign cur_we    = in_split ? we_q    : req_we;
    assign cur_wdata = in_split ? wdata_q : req_wdata;
`else
    logic [OW-1:0] align_mask;
    logic          misaligned;

    always_comb begin
        nbytes     = size_to_bytes(req_size, NB);
        size_bad   = (req_size == SZ_ILLEGAL);
        align_mask = OW'(nbytes - 1);
        misaligned = |(req_off & align_mask);
        err        = size_bad | misaligned;
    end

    assign in_split  = 1'b0;
    assign cur_row   = req_row;
    assign cur_off   = req_off;
    assign cur_size  = req_size;
    assign cur_sgn   = req_signed;
    assign cur_we    = req_we;
    assign cur_wdata = req_wdata;
`endif

    // Row addresses wrap naturally at the top of memory
    assign row1_a = cur_row + RW'(1);
    assign waddr  = in_split ? row1_a : cur_row;
    assign rd0    = mem_delta[cur_row] ^ preload_row(cur_row);
    assign rd1    = mem_delta[row1_a] ^ preload_row(row1_a);
    assign wpre   = preload_row(waddr);
    assign mem_we = (accept & ~err & req_we) | (in_split & cur_we);

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .off   (cur_off),
        .size  (cur_size),
        .sgn   (cur_sgn),
        .hi    (in_split),
        .wdata (cur_wdata),
        .row0  (rd0),
        .row1  (rd1),
        .wmask (wmask),
        .wrow  (wrow),
        .rdata (rdata_al)
    );

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wmask[i]) mem_delta[waddr][i*8 +: 8] <= wrow[i*8 +: 8] ^ wpre[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (err) begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= ST_RESP;
                        end
`ifdef DMEM_BANKED_MISALIGN_EN
                        else if (cross) begin
                            state_q <= ST_SPLIT;
                        end
`endif
                        else begin
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= req_we ? '0 : rdata_al;
                            state_q     <= ST_RESP;
                        end
                    end
                end
`ifdef DMEM_BANKED_MISALIGN_EN
                ST_SPLIT: begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= cur_we ? '0 : rdata_al;
                    state_q     <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_banked.sv
// Directed bench for dmem_banked (default geometry ADDR_W=10, DATA_W=32).
// Expectations follow DMEM_BANKED_MISALIGN_EN when the bench is built with it.
module tb_dmem_banked;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    dmem_banked #(
        .ADDR_W (10),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [9:0] addr, input logic [31:0] wdata);
        int n;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rdata, output logic err, output int l);
        l = 1;
        while (!rsp_valid && l < 8) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    // Full transaction with rsp_ready held high; ends back in IDLE.
    task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int l);
        send(we, size, sgn, addr, wdata);
        wait_rsp(rdata, err, l);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Preloaded loads
        xact(1'b0, SZ_WORD, 1'b0, 10'd8, 32'd0, rd, er, lat);
        check("lw8_data", rd, 32'h1234_5678);
        check("lw8_err", {31'd0, er}, 32'd0);
        check("lw8_latency", 32'(lat), 32'd1);
        xact(1'b0, SZ_BYTE, 1'b1, 10'd7, 32'd0, rd, er, lat);
        check("lb7_signed", rd, 32'hFFFF_FF99);
        xact(1'b0, SZ_BYTE, 1'b0, 10'd7, 32'd0, rd, er, lat);
        check("lb7_unsigned", rd, 32'h0000_0099);
        xact(1'b0, SZ_HALF, 1'b1, 10'd4, 32'd0, rd, er, lat);
        check("lh4_signed", rd, 32'h0000_7254);
        xact(1'b0, SZ_HALF, 1'b1, 10'd6, 32'd0, rd, er, lat);
        check("lh6_signed", rd, 32'hFFFF_9912);
        xact(1'b0, SZ_BYTE, 1'b0, 10'd12, 32'd0, rd, er, lat);
        check("lb12_unsigned", rd, 32'h0000_0043);
        xact(1'b0, SZ_WORD, 1'b1, 10'd12, 32'd0, rd, er, lat);
        check("lw12_signed_ignored", rd, 32'h8911_7843);

        // Byte store leaves neighbouring lanes alone
        xact(1'b1, SZ_BYTE, 1'b0, 10'd5, 32'hFFFF_FFAB, rd, er, lat);
        check("sb5_rdata", rd, 32'd0);
        check("sb5_err", {31'd0, er}, 32'd0);
        xact(1'b0, SZ_WORD, 1'b0, 10'd4, 32'd0, rd, er, lat);
        check("lw4_after_sb", rd, 32'h9912_AB54);

        // Response held under back-pressure
        rsp_ready = 1'b0;
        send(1'b0, SZ_WORD, 1'b0, 10'd16, 32'd0);
        wait_rsp(rd, er, lat);
        check("stall_first_data", rd, 32'h1241_8549);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rdata", rsp_rdata, 32'h1241_8549);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = SZ_WORD;
        req_addr   = 10'd8;
        @(posedge clk);
        #1;
        check("release_valid_drop", {31'd0, rsp_valid}, 32'd0);
        check("release_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp(rd, er, lat);
        check("post_stall_data", rd, 32'h1234_5678);
        check("post_stall_latency", 32'(lat), 32'd1);
        @(posedge clk);
        #1;

        // Misaligned word load
        xact(1'b0, SZ_WORD, 1'b0, 10'd6, 32'd0, rd, er, lat);
`ifdef DMEM_BANKED_MISALIGN_EN
        check("lw6_data", rd, 32'h5678_9912);
        check("lw6_err", {31'd0, er}, 32'd0);
        check("lw6_latency", 32'(lat), 32'd2);
`else
        check("lw6_data", rd, 32'd0);
        check("lw6_err", {31'd0, er}, 32'd1);
        check("lw6_latency", 32'(lat), 32'd1);
        xact(1'b1, SZ_HALF, 1'b0, 10'd9, 32'h0000_BEEF, rd, er, lat);
        check("sh9_err", {31'd0, er}, 32'd1);
        xact(1'b0, SZ_WORD, 1'b0, 10'd8, 32'd0, rd, er, lat);
        check("lw8_after_bad_sh", rd, 32'h1234_5678);
`endif

        // Illegal size: error, no write
        xact(1'b1, SZ_ILLEGAL, 1'b0, 10'd0, 32'hDEAD_BEEF, rd, er, lat);
        check("sz3_err", {31'd0, er}, 32'd1);
        check("sz3_rdata", rd, 32'd0);
        xact(1'b0, SZ_WORD, 1'b0, 10'd0, 32'd0, rd, er, lat);
        check("lw0_after_sz3", rd, 32'd0);

        // Top-of-memory accesses
        xact(1'b1, SZ_WORD, 1'b0, 10'd1020, 32'hCAFE_F00D, rd, er, lat);
        xact(1'b0, SZ_HALF, 1'b0, 10'd1022, 32'd0, rd, er, lat);
        check("lh1022_unsigned", rd, 32'h0000_CAFE);
        xact(1'b0, SZ_BYTE, 1'b1, 10'd1020, 32'd0, rd, er, lat);
        check("lb1020_signed", rd, 32'h0000_000D);
`ifdef DMEM_BANKED_MISALIGN_EN
        xact(1'b1, SZ_WORD, 1'b0, 10'd1022, 32'h1122_3344, rd, er, lat);
        check("sw1022_latency", 32'(lat), 32'd2);
        xact(1'b0, SZ_WORD, 1'b0, 10'd1020, 32'd0, rd, er, lat);
        check("wrap_top_row", rd, 32'h3344_F00D);
        xact(1'b0, SZ_WORD, 1'b0, 10'd0, 32'd0, rd, er, lat);
        check("wrap_row0", rd, 32'h0000_1122);

        // Reset while in SPLIT: first row written, second dropped
        send(1'b1, SZ_WORD, 1'b0, 10'd1022, 32'h5566_7788);
        reset = 1'b0;
        #1;
        check("rst_split_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_split_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_split_ready_after", {31'd0, req_ready}, 32'd1);
        check("rst_split_valid_after", {31'd0, rsp_valid}, 32'd0);
        xact(1'b0, SZ_WORD, 1'b0, 10'd1020, 32'd0, rd, er, lat);
        check("rst_split_first_row", rd, 32'h7788_F00D);
        xact(1'b0, SZ_WORD, 1'b0, 10'd0, 32'd0, rd, er, lat);
        check("rst_split_second_row", rd, 32'h0000_1122);
`else
        // Reset while a response is pending: the store persists, no response
        send(1'b1, SZ_WORD, 1'b0, 10'd20, 32'hA5A5_A5A5);
        reset = 1'b0;
        #1;
        check("rst_resp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_resp_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_resp_ready_after", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid_after", {31'd0, rsp_valid}, 32'd0);
        xact(1'b0, SZ_WORD, 1'b0, 10'd20, 32'd0, rd, er, lat);
        check("rst_resp_store_kept", rd, 32'hA5A5_A5A5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
